blowfish_feistel_engine: RTL and testbench
==========================================

// Module: blowfish_feistel_engine
// PURPOSE
//  Iterative, parametrised Blowfish-family Feistel engine; generalises the fixed 128-bit top to any half-width and round count.
//  Holds the P-array in a local register file loaded by the key-schedule unit; sequences ROUNDS rounds through an external F unit.
//  Supports encrypt and decrypt per block. Block interfaces use valid/ready; output is buffered until consumed.
//  Sits between the stream front-end and the S-box F unit, replacing per-block key regeneration with a cached P-array.
// PARAMETERS
//  HALF_W  32  half-block width (32 = Blowfish-64, 64 = Blowfish-128); block width = 2*HALF_W
//  ROUNDS  16  Feistel rounds, even, >=2; P-array depth = ROUNDS+2
// PORTS
//  Clk          in   1                  clock, rising edge
//  Rst          in   1                  synchronous, active-high reset
//  key_wr_en    in   1                  write one P entry
//  key_wr_idx   in   $clog2(ROUNDS+2)   P index; idx >= ROUNDS+2 is ignored
//  key_wr_data  in   HALF_W             P entry value
//  key_done     in   1                  P-array complete; sets key_valid
//  key_valid    out  1                  P-array usable
//  key_wr_err   out  1                  1-cycle pulse: key_wr_en/key_done dropped while busy
//  in_valid     in   1                  block offered
//  in_ready     out  1                  engine accepts block
//  in_encrypt   in   1                  1 = encrypt, 0 = decrypt; sampled with block
//  in_data      in   2*HALF_W           {L,R}, L = MSB half
//  out_valid    out  1                  result held
//  out_ready    in   1                  consumer takes result
//  out_data     out  2*HALF_W           {L,R} result
//  f_req        out  1                  F request
//  f_x          out  HALF_W             F input
//  f_ack        in   1                  F result valid this cycle
//  f_y          in   HALF_W             F(f_x)
//  busy         out  1                  state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0; P-array cleared; key_valid=0; FSM=IDLE. Rst mid-block aborts; the block is lost and no out_valid is produced.
//  Key load: key_wr_en in IDLE writes P[idx] and clears key_valid the same cycle. key_done sets key_valid next cycle.
//    Write plus done in the same cycle: the write lands and key_valid=1.
//    While busy, both are ignored and key_wr_err pulses.
//  in_ready = IDLE & key_valid & (!out_valid | out_ready). A handshake latches L, R, mode and round cnt=0; FSM goes to ROUND.
//  P order: encrypt uses k(i)=P[i]; decrypt uses k(i)=P[ROUNDS+1-i].
//  ROUND (cnt<ROUNDS):
//    f_req=1; f_x = L ^ k(cnt), held stable until f_ack.
//    On f_ack: L <= R ^ f_y; R <= L ^ k(cnt); cnt++.
//    If cnt==ROUNDS-1 go to FINAL.
//    f_ack while f_req=0 is ignored.
//  FINAL, one cycle, undoes the last swap:
//    out_data <= {R ^ k(ROUNDS+1), L ^ k(ROUNDS)} using the current L,R.
//    out_valid=1; FSM goes to IDLE.
//  Latency with f_ack tied high: out_valid rises ROUNDS+1 cycles after the in handshake edge. Each F wait cycle adds 1.
//  Output: out_valid and out_data hold until out_ready. Clears on out_valid & out_ready unless FINAL reloads it in the same cycle.
//  A new block can be accepted in the cycle its predecessor's result is taken.
//  Arithmetic: XOR only, HALF_W-wide. cnt is $clog2(ROUNDS+1) bits and never wraps.
// TESTING
//  T1 ROUNDS=16, HALF_W=32, all P=0, F model returns 0:
//     in 64'h0123456789ABCDEF enc -> out 64'h89ABCDEF01234567.
//  T2 P and S-box F from the golden key schedule for key 64'h0:
//     enc 64'h0 -> 64'h4EF997456198DD78; decrypt of that -> 64'h0.
//  T3 f_ack tied high -> out_valid exactly 17 cycles after handshake.
//     Random 0-3 cycle f_ack delays -> latency = 17 + sum of delays, f_x stable while waiting.
//  T4 out_ready low 5 cycles with a second block pending:
//     out_data unchanged, in_ready=0; in the out_ready=1 cycle the next block is accepted.
//  T5 key_wr_en pulse mid-block -> key_wr_err=1 for 1 cycle, P unchanged, result still matches golden.
//     Idle write -> key_valid=0, in_ready=0 until key_done.
//  T6 Rst at round 8 -> next cycle out_valid=0, busy=0, key_valid=0, no stale output afterwards.
//     HALF_W=64 build: T1 pattern yields the swapped halves.

Source files
------------

// File: rtl/blowfish_feistel_engine.sv
// Iterative Blowfish-family Feistel engine with a cached P-array and an external F unit.
// One round is taken per F acknowledge; a FINAL cycle undoes the last swap and applies the whitening keys.
module blowfish_feistel_engine #(
    parameter int HALF_W = 32,
    parameter int ROUNDS = 16
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic                          key_wr_en,
    input  logic [$clog2(ROUNDS+2)-1:0]   key_wr_idx,
    input  logic [HALF_W-1:0]             key_wr_data,
    input  logic                          key_done,
    output logic                          key_valid,
    output logic                          key_wr_err,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_encrypt,
    input  logic [2*HALF_W-1:0]           in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*HALF_W-1:0]           out_data,
    output logic                          f_req,
    output logic [HALF_W-1:0]             f_x,
    input  logic                          f_ack,
    input  logic [HALF_W-1:0]             f_y,
    output logic                          busy
);
    localparam int unsigned P_DEPTH = ROUNDS + 2;
    localparam int          IDX_W   = $clog2(ROUNDS + 2);
    localparam int          CNT_W   = $clog2(ROUNDS + 1);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROUNDS + 1);
    localparam logic [IDX_W-1:0] IDX_PEN  = IDX_W'(ROUNDS);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_ZERO = '0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    logic [1:0]        state;
    logic [HALF_W-1:0] p_arr [P_DEPTH];
    logic [HALF_W-1:0] l_q;
    logic [HALF_W-1:0] r_q;
    logic              enc_q;
    logic [CNT_W-1:0]  cnt;

    logic [IDX_W-1:0]  k_idx;
    logic [HALF_W-1:0] k_fin_l;
    logic [HALF_W-1:0] k_fin_r;
    logic              idx_ok;

    // Decrypt walks the P-array backwards, so the whitening pair swaps ends too.
    assign k_idx   = enc_q ? IDX_W'(cnt) : IDX_LAST - IDX_W'(cnt);
    assign k_fin_l = enc_q ? p_arr[IDX_LAST] : p_arr[IDX_ZERO];
    assign k_fin_r = enc_q ? p_arr[IDX_PEN]  : p_arr[IDX_ONE];
    assign idx_ok  = {1'b0, key_wr_idx} < (IDX_W + 1)'(P_DEPTH);

    assign busy     = (state != S_IDLE);
    assign f_req    = (state == S_ROUND);
    assign f_x      = l_q ^ p_arr[k_idx];
    assign in_ready = (state == S_IDLE) && key_valid && (!out_valid || out_ready);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= S_IDLE;
            l_q        <= '0;
            r_q        <= '0;
            enc_q      <= 1'b0;
            cnt        <= '0;
            key_valid  <= 1'b0;
            key_wr_err <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            for (int unsigned i = 0; i < P_DEPTH; i++) begin
                p_arr[i] <= '0;
            end
        end else begin
            key_wr_err <= 1'b0;
            if (state == S_IDLE) begin
                if (key_wr_en && idx_ok) begin
                    p_arr[key_wr_idx] <= key_wr_data;
                    key_valid         <= key_done;
                end else if (key_done) begin
                    key_valid <= 1'b1;
                end
            end else if (key_wr_en || key_done) begin
                key_wr_err <= 1'b1;
            end

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        l_q   <= in_data[2*HALF_W-1:HALF_W];
                        r_q   <= in_data[HALF_W-1:0];
                        enc_q <= in_encrypt;
                        cnt   <= '0;
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (f_ack) begin
                        l_q <= r_q ^ f_y;
                        r_q <= f_x;
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_W'(ROUNDS - 1)) begin
                            state <= S_FINAL;
                        end
                    end
                end
                S_FINAL: begin
                    out_data  <= {r_q ^ k_fin_l, l_q ^ k_fin_r};
                    out_valid <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_blowfish_feistel_engine.sv
// Scoreboard bench for blowfish_feistel_engine: expected blocks come from a textbook-form Feistel model
// driven by a bench-side P-array copy and a nonlinear stand-in F function with random acknowledge delay.
module tb_blowfish_feistel_engine;
    localparam int HW = 32;
    localparam int NR = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_wr_en = 1'b0;
    logic [4:0]  key_wr_idx = '0;
    logic [31:0] key_wr_data = '0;
    logic        key_done = 1'b0;
    logic        key_valid, key_wr_err;
    logic        in_valid = 1'b0;
    logic        in_encrypt = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        f_req;
    logic [31:0] f_x;
    logic        f_ack;
    logic [31:0] f_y;
    logic        busy;

    logic         key_done_w = 1'b0;
    logic         key_valid_w, key_wr_err_w;
    logic         in_valid_w = 1'b0;
    logic [127:0] in_data_w = '0;
    logic         in_ready_w, out_valid_w, out_ready_w = 1'b0;
    logic [127:0] out_data_w;
    logic         f_req_w, busy_w;
    logic [63:0]  f_x_w;
    logic         f_ack_w = 1'b1;
    logic [63:0]  f_y_w = '0;
    logic         key_wr_en_w = 1'b0;
    logic [4:0]   key_wr_idx_w = '0;
    logic [63:0]  key_wr_data_w = '0;

    int tests = 0;
    int fails = 0;
    logic [63:0]  exp_q[$];
    logic [127:0] exp_wq[$];
    logic [31:0]  tb_p [NR+2];

    logic        f_zero = 1'b1;
    int unsigned f_dly_max = 0;
    int unsigned f_wait = 0;
    int unsigned f_target = 0;
    int unsigned f_stalls = 0;

    blowfish_feistel_engine #(.HALF_W(HW), .ROUNDS(NR)) dut (
        .Clk(clk), .Rst(rst),
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .key_done(key_done), .key_valid(key_valid), .key_wr_err(key_wr_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_encrypt(in_encrypt), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .f_req(f_req), .f_x(f_x), .f_ack(f_ack), .f_y(f_y), .busy(busy)
    );

    blowfish_feistel_engine #(.HALF_W(64), .ROUNDS(NR)) dut_w (
        .Clk(clk), .Rst(rst),
        .key_wr_en(key_wr_en_w), .key_wr_idx(key_wr_idx_w), .key_wr_data(key_wr_data_w),
        .key_done(key_done_w), .key_valid(key_valid_w), .key_wr_err(key_wr_err_w),
        .in_valid(in_valid_w), .in_ready(in_ready_w), .in_encrypt(1'b1), .in_data(in_data_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out_data(out_data_w),
        .f_req(f_req_w), .f_x(f_x_w), .f_ack(f_ack_w), .f_y(f_y_w), .busy(busy_w)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_func(input logic [31:0] x);
        return (x * 32'h9E3779B1) ^ {x[12:0], x[31:13]} ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] fz(input logic [31:0] x);
        return f_zero ? 32'h0 : f_func(x);
    endfunction

    function automatic logic [31:0] kk(input int i, input logic enc);
        return enc ? tb_p[i] : tb_p[NR + 1 - i];
    endfunction

    // Textbook form: xor key into L, xor F(L) into R, swap; undo the final swap then whiten.
    function automatic logic [63:0] model(input logic [63:0] blk, input logic enc);
        logic [31:0] xl, xr, t;
        xl = blk[63:32];
        xr = blk[31:0];
        for (int i = 0; i < NR; i++) begin
            xl = xl ^ kk(i, enc);
            xr = xr ^ fz(xl);
            t = xl; xl = xr; xr = t;
        end
        t = xl; xl = xr; xr = t;
        xr = xr ^ kk(NR, enc);
        xl = xl ^ kk(NR + 1, enc);
        return {xl, xr};
    endfunction

    always_comb f_ack = f_req && (f_wait >= f_target);
    always_comb f_y = fz(f_x);

    always @(posedge clk) begin
        if (!f_req) begin
            f_wait <= 0;
        end else if (f_ack) begin
            f_wait   <= 0;
            f_target <= $urandom_range(f_dly_max, 0);
        end else begin
            f_wait   <= f_wait + 1;
            f_stalls <= f_stalls + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got stuck want finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        for (int i = 0; i < NR + 2; i++) tb_p[i] = '0;
    endtask

    task automatic load_key;
        for (int i = 0; i < NR + 2; i++) begin
            key_wr_en   = 1'b1;
            key_wr_idx  = 5'(i);
            key_wr_data = $urandom;
            tb_p[i]     = key_wr_data;
            key_done    = (i == NR + 1);
            cyc(1);
        end
        key_wr_en = 1'b0;
        key_done  = 1'b0;
    endtask

    task automatic send(input logic [63:0] d, input logic enc, input bit push, output bit ok);
        int n;
        in_valid = 1'b1;
        in_data = d;
        in_encrypt = enc;
        n = 0;
        while (!in_ready && n < 200) begin
            cyc(1);
            n++;
        end
        ok = in_ready;
        if (ok) cyc(1);
        in_valid = 1'b0;
        if (ok && push) exp_q.push_back(model(d, enc));
    endtask

    task automatic wait_out(output logic [63:0] d, output int lat);
        lat = 0;
        while (!out_valid && lat < 300) begin
            cyc(1);
            lat++;
        end
        if (!out_valid) lat = -1;
        d = out_data;
    endtask

    task automatic take_out;
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        tests++;
        if ({out_valid, busy, key_valid, in_ready, f_req, key_wr_err} !== 6'b0) begin
            fails++;
            $display("FAIL reset_flags: got %b want 000000", {out_valid, busy, key_valid, in_ready, f_req, key_wr_err});
        end
        tests++;
        if (out_data !== 64'h0) begin
            fails++;
            $display("FAIL reset_out_data: got %h want 0", out_data);
        end
        tests++;
        if (f_x !== 32'h0) begin
            fails++;
            $display("FAIL reset_f_x: got %h want 0", f_x);
        end
    endtask

    task automatic test_zero_key;
        logic [63:0] d, e;
        int lat;
        bit ok;
        f_zero = 1'b1;
        f_dly_max = 0;
        key_done = 1'b1;
        cyc(1);
        key_done = 1'b0;
        tests++;
        if (key_valid !== 1'b1) begin
            fails++;
            $display("FAIL zero_key_valid: got %b want 1", key_valid);
        end
        send(64'h0123456789ABCDEF, 1'b1, 1'b0, ok);
        exp_q.push_back(64'h89ABCDEF01234567);
        wait_out(d, lat);
        e = exp_q.pop_front();
        tests++;
        if (lat != NR + 1) begin
            fails++;
            $display("FAIL zero_key_latency: got %0d want %0d", lat, NR + 1);
        end
        tests++;
        if (d !== e) begin
            fails++;
            $display("FAIL zero_key_data: got %h want %h", d, e);
        end
        take_out();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL zero_key_out_clear: got %b want 0", out_valid);
        end
    endtask

    task automatic test_enc_dec;
        logic [63:0] pt, ct, d, e;
        int lat;
        bit ok;
        f_zero = 1'b0;
        load_key();
        tests++;
        if (key_valid !== 1'b1) begin
            fails++;
            $display("FAIL key_load_valid: got %b want 1", key_valid);
        end
        for (int i = 0; i < 4; i++) begin
            pt = {$urandom, $urandom};
            send(pt, 1'b1, 1'b1, ok);
            wait_out(d, lat);
            e = exp_q.pop_front();
            tests++;
            if (d !== e) begin
                fails++;
                $display("FAIL encrypt_%0d: got %h want %h", i, d, e);
            end
            ct = d;
            take_out();
            send(ct, 1'b0, 1'b1, ok);
            wait_out(d, lat);
            e = exp_q.pop_front();
            tests++;
            if (d !== e || d !== pt) begin
                fails++;
                $display("FAIL decrypt_%0d: got %h want %h", i, d, pt);
            end
            take_out();
        end
    endtask

    task automatic test_latency;
        logic [63:0] d, e, prev_x;
        int lat;
        int unsigned s0;
        bit ok, prev_hold, stable_ok;
        f_dly_max = 3;
        for (int i = 0; i < 4; i++) begin
            send({$urandom, $urandom}, 1'(i % 2), 1'b1, ok);
            s0 = f_stalls;
            lat = 0;
            prev_hold = 1'b0;
            stable_ok = 1'b1;
            prev_x = '0;
            while (!out_valid && lat < 400) begin
                prev_hold = f_req && !f_ack;
                prev_x = {32'h0, f_x};
                cyc(1);
                lat++;
                if (prev_hold && f_req && ({32'h0, f_x} !== prev_x)) stable_ok = 1'b0;
            end
            tests++;
            if (!stable_ok) begin
                fails++;
                $display("FAIL f_x_stable_%0d: got unstable want stable", i);
            end
            tests++;
            if (!out_valid || lat != NR + 1 + int'(f_stalls - s0)) begin
                fails++;
                $display("FAIL latency_%0d: got %0d want %0d", i, lat, NR + 1 + int'(f_stalls - s0));
            end
            e = exp_q.pop_front();
            tests++;
            if (out_data !== e) begin
                fails++;
                $display("FAIL latency_data_%0d: got %h want %h", i, out_data, e);
            end
            take_out();
        end
        f_dly_max = 0;
    endtask

    task automatic test_back_to_back;
        logic [63:0] held, b, e;
        int lat, bad;
        bit ok;
        send({$urandom, $urandom}, 1'b1, 1'b1, ok);
        wait_out(held, lat);
        b = {$urandom, $urandom};
        in_valid = 1'b1;
        in_data = b;
        in_encrypt = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== held) bad++;
            cyc(1);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL backpressure_hold: got %0d bad cycles want 0", bad);
        end
        e = exp_q.pop_front();
        tests++;
        if (held !== e) begin
            fails++;
            $display("FAIL backpressure_data: got %h want %h", held, e);
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL take_cycle_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        exp_q.push_back(model(b, 1'b0));
        tests++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL take_cycle_accept: got busy=%b out_valid=%b want busy=1 out_valid=0", busy, out_valid);
        end
        wait_out(held, lat);
        e = exp_q.pop_front();
        tests++;
        if (held !== e) begin
            fails++;
            $display("FAIL second_block_data: got %h want %h", held, e);
        end
        take_out();
    endtask

    task automatic test_key_err;
        logic [63:0] d, e;
        int lat;
        bit ok;
        send({$urandom, $urandom}, 1'b1, 1'b1, ok);
        cyc(3);
        key_wr_en = 1'b1;
        key_wr_idx = 5'd0;
        key_wr_data = 32'hDEADBEEF;
        cyc(1);
        key_wr_en = 1'b0;
        tests++;
        if (key_wr_err !== 1'b1) begin
            fails++;
            $display("FAIL key_err_pulse: got %b want 1", key_wr_err);
        end
        cyc(1);
        tests++;
        if (key_wr_err !== 1'b0) begin
            fails++;
            $display("FAIL key_err_one_cycle: got %b want 0", key_wr_err);
        end
        wait_out(d, lat);
        e = exp_q.pop_front();
        tests++;
        if (d !== e) begin
            fails++;
            $display("FAIL key_err_data: got %h want %h", d, e);
        end
        take_out();
        key_wr_en = 1'b1;
        key_wr_idx = 5'd31;
        key_wr_data = 32'h12345678;
        cyc(1);
        key_wr_en = 1'b0;
        tests++;
        if (key_valid !== 1'b1) begin
            fails++;
            $display("FAIL bad_idx_ignored: got key_valid=%b want 1", key_valid);
        end
        key_wr_en = 1'b1;
        key_wr_idx = 5'd5;
        key_wr_data = $urandom;
        tb_p[5] = key_wr_data;
        cyc(1);
        key_wr_en = 1'b0;
        cyc(2);
        tests++;
        if (key_valid !== 1'b0 || in_ready !== 1'b0 || key_wr_err !== 1'b0) begin
            fails++;
            $display("FAIL idle_write: got valid=%b ready=%b err=%b want 0 0 0", key_valid, in_ready, key_wr_err);
        end
        key_done = 1'b1;
        cyc(1);
        key_done = 1'b0;
        tests++;
        if (key_valid !== 1'b1) begin
            fails++;
            $display("FAIL key_done_restore: got %b want 1", key_valid);
        end
        send({$urandom, $urandom}, 1'b1, 1'b1, ok);
        wait_out(d, lat);
        e = exp_q.pop_front();
        tests++;
        if (d !== e) begin
            fails++;
            $display("FAIL new_key_data: got %h want %h", d, e);
        end
        take_out();
    endtask

    task automatic test_reset_mid;
        bit ok, saw;
        send({$urandom, $urandom}, 1'b1, 1'b0, ok);
        cyc(8);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        for (int i = 0; i < NR + 2; i++) tb_p[i] = '0;
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || key_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got out_valid=%b busy=%b key_valid=%b want 0 0 0", out_valid, busy, key_valid);
        end
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) saw = 1'b1;
            cyc(1);
        end
        tests++;
        if (saw) begin
            fails++;
            $display("FAIL mid_reset_stale: got out_valid=1 want 0");
        end
    endtask

    task automatic test_wide;
        logic [127:0] e;
        int n, lat;
        key_done_w = 1'b1;
        cyc(1);
        key_done_w = 1'b0;
        in_valid_w = 1'b1;
        in_data_w = 128'h0123456789ABCDEF_FEDCBA9876543210;
        n = 0;
        while (!in_ready_w && n < 50) begin
            cyc(1);
            n++;
        end
        cyc(1);
        in_valid_w = 1'b0;
        exp_wq.push_back(128'hFEDCBA9876543210_0123456789ABCDEF);
        lat = 0;
        while (!out_valid_w && lat < 100) begin
            cyc(1);
            lat++;
        end
        e = exp_wq.pop_front();
        tests++;
        if (!out_valid_w || lat != NR + 1) begin
            fails++;
            $display("FAIL wide_latency: got %0d want %0d", lat, NR + 1);
        end
        tests++;
        if (out_data_w !== e) begin
            fails++;
            $display("FAIL wide_data: got %h want %h", out_data_w, e);
        end
        out_ready_w = 1'b1;
        cyc(1);
        out_ready_w = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();
        test_reset();
        test_zero_key();
        test_enc_dec();
        test_latency();
        test_back_to_back();
        test_key_err();
        test_reset_mid();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
